// File: rtl/rstcond_pkg.sv
// rstcond_pkg: state encoding, reset cause codes and counter sizing for rst_conditioner
package rstcond_pkg;
  typedef enum logic [1:0] {HOLD, RUN, DB_PRESS, WAIT_REL} state_e;
  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_BTN = 2'b01,
    CAUSE_PLL = 2'b10,
    CAUSE_SW  = 2'b11
  } cause_e;
  localparam logic [7:0] COUNT_MAX = 8'hFF;
  // Width of a counter that has to reach max(a, b) - 1
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/rstcond_sync.sv
// rstcond_sync: STAGES-deep flop synchronizer for an asynchronous level, cleared to 0 on reset
module rstcond_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  // Shift the raw level through the chain; the oldest sample is the output
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= (sync_q << 1) | STAGES'(d_i);
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/rst_conditioner.sv
// rst_conditioner: merges POR, PLL lock loss, debounced button and (with RSTCOND_SW_RST_EN) software reset into erst_n
module rst_conditioner
  import rstcond_pkg::*;
#(
  parameter int HOLD_CYC     = 256,
  parameter int DEBOUNCE_CYC = 16000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       btn_rst_n,
`ifdef RSTCOND_SW_RST_EN
  input  logic       sw_rst_req,
`endif
  output logic       erst_n,
  output logic       rst_active,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);
  localparam int CW = cnt_width(HOLD_CYC, DEBOUNCE_CYC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
  logic arm_q;
  logic lock_s, btn_s, sw_req, bump;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic erst_n_q, erst_n_d, rst_active_q;
  cause_e cause_q, cause_d;
  logic [7:0] count_q, count_d;
`ifdef RSTCOND_SW_RST_EN
  assign sw_req = sw_rst_req;
`else
  assign sw_req = 1'b0;
`endif
  // Synchronizers only see the real inputs once reset release has been retimed by arm_q
  rstcond_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .d_i   (arm_q & pll_lock),
    .q_o   (lock_s)
  );
  rstcond_sync #(.STAGES(SYNC_STAGES)) u_sync_btn (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .d_i   (arm_q & btn_rst_n),
    .q_o   (btn_s)
  );
  // Next state: PLL loss beats software request beats button; cnt clears on every state change
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    erst_n_d = erst_n_q;
    cause_d  = cause_q;
    bump     = 1'b0;
    case (state_q)
      HOLD:
        if (!(lock_s && btn_s)) cnt_d = '0;
        else if (cnt_q == HOLD_LAST) begin
          state_d  = RUN;
          cnt_d    = '0;
          erst_n_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      RUN, DB_PRESS:
        if (!lock_s || sw_req) begin
          state_d  = HOLD;
          cnt_d    = '0;
          erst_n_d = 1'b0;
          cause_d  = !lock_s ? CAUSE_PLL : CAUSE_SW;
          bump     = 1'b1;
        end else if (state_q == RUN) begin
          if (!btn_s) begin
            state_d = DB_PRESS;
            cnt_d   = '0;
          end
        end else if (btn_s) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d  = WAIT_REL;
          cnt_d    = '0;
          erst_n_d = 1'b0;
          cause_d  = CAUSE_BTN;
          bump     = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      default:
        if (!btn_s) cnt_d = '0;
        else if (cnt_q == DB_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
    endcase
    count_d = (bump && count_q != COUNT_MAX) ? count_q + 8'd1 : count_q;
  end
  // State and registered outputs; rst_n clears everything at once and arm_q retimes its release
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      arm_q        <= 1'b0;
      state_q      <= HOLD;
      cnt_q        <= '0;
      erst_n_q     <= 1'b0;
      rst_active_q <= 1'b1;
      cause_q      <= CAUSE_POR;
      count_q      <= '0;
    end else begin
      arm_q        <= 1'b1;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      erst_n_q     <= erst_n_d;
      rst_active_q <= ~erst_n_d;
      cause_q      <= cause_d;
      count_q      <= count_d;
    end
  assign erst_n     = erst_n_q;
  assign rst_active = rst_active_q;
  assign rst_cause  = cause_q;
  assign rst_count  = count_q;
endmodule
